// File: rtl/qdec_cabac_frame_seq.sv
// Frame sequencer for the CABAC decoder: programs five header registers plus START,
// then supervises CTU/done/error interrupts and reports a per-frame status.
module qdec_cabac_frame_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frm_vld,
   output logic              frm_rdy,
   input  logic [31:0]       frm_vps0,
   input  logic [31:0]       frm_sps0,
   input  logic [31:0]       frm_sps1,
   input  logic [31:0]       frm_pps0,
   input  logic [31:0]       frm_slh0,
   input  logic [15:0]       frm_num_ctu,
   output logic              reg_req_vld,
   input  logic              reg_req_rdy,
   output logic [ADDR_W-1:0] reg_req_addr,
   output logic [31:0]       reg_req_wdata,
   input  logic              reg_resp_vld,
   input  logic              ctu_done_intr,
   input  logic              done_intr,
   input  logic              error_intr,
   output logic              busy,
   output logic              frm_done,
   output logic [1:0]        frm_status,
   output logic [15:0]       ctu_cnt
);

   localparam logic [31:0] ADDR_CABAC_VPS_0          = 32'h0000_0100;
   localparam logic [31:0] ADDR_CABAC_SPS_0          = 32'h0000_0104;
   localparam logic [31:0] ADDR_CABAC_SPS_1          = 32'h0000_0108;
   localparam logic [31:0] ADDR_CABAC_PPS_0          = 32'h0000_010C;
   localparam logic [31:0] ADDR_CABAC_SLICE_HEADER_0 = 32'h0000_0110;
   localparam logic [31:0] ADDR_CABAC_START          = 32'h0000_0000;
   localparam logic [31:0] TMO_LAST                  = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [4:0][31:0] words_q, words_d;
   logic [15:0]      num_ctu_q, num_ctu_d;
   logic [15:0]      cnt_q, cnt_d, cnt_nxt;
   logic [31:0]      tmo_q, tmo_d;
   logic [1:0]       status_q, status_d;
   logic [31:0]      addr_w;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      words_d   = words_q;
      num_ctu_d = num_ctu_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      status_d  = status_q;
      cnt_nxt   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (frm_vld) begin
               words_d   = {frm_slh0, frm_pps0, frm_sps1, frm_sps0, frm_vps0};
               num_ctu_d = frm_num_ctu;
               cnt_d     = '0;
               idx_d     = '0;
               state_d   = StWrReq;
            end
         end
         StWrReq: begin
            if (reg_req_rdy) state_d = StWrResp;
         end
         StWrResp: begin
            if (reg_resp_vld) begin
               if (idx_q < 3'd5) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StWrReq;
               end else begin
                  tmo_d   = '0;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            // A CTU pulse always counts, even when it coincides with the exit event.
            if (ctu_done_intr && (cnt_q != 16'hFFFF)) cnt_nxt = cnt_q + 16'd1;
            cnt_d = cnt_nxt;
            tmo_d = ctu_done_intr ? '0 : tmo_q + 32'd1;
            if (error_intr) begin
               status_d = 2'd1;
               state_d  = StDone;
            end else if (done_intr) begin
               status_d = (cnt_nxt == num_ctu_q) ? 2'd0 : 2'd3;
               state_d  = StDone;
            end else if ((tmo_q == TMO_LAST) && !ctu_done_intr) begin
               status_d = 2'd2;
               state_d  = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         words_q   <= '0;
         num_ctu_q <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         status_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         words_q   <= words_d;
         num_ctu_q <= num_ctu_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         status_q  <= status_d;
      end
   end

   always_comb begin
      addr_w        = ADDR_CABAC_START;
      reg_req_wdata = 32'h0;
      unique case (idx_q)
         3'd0: begin addr_w = ADDR_CABAC_VPS_0;          reg_req_wdata = words_q[0]; end
         3'd1: begin addr_w = ADDR_CABAC_SPS_0;          reg_req_wdata = words_q[1]; end
         3'd2: begin addr_w = ADDR_CABAC_SPS_1;          reg_req_wdata = words_q[2]; end
         3'd3: begin addr_w = ADDR_CABAC_PPS_0;          reg_req_wdata = words_q[3]; end
         3'd4: begin addr_w = ADDR_CABAC_SLICE_HEADER_0; reg_req_wdata = words_q[4]; end
         3'd5: begin addr_w = ADDR_CABAC_START;          reg_req_wdata = 32'h1;      end
         default: ;
      endcase
   end

   assign reg_req_addr = ADDR_W'(addr_w);
   assign frm_rdy      = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign reg_req_vld  = (state_q == StWrReq);
   assign frm_done     = (state_q == StDone);
   assign frm_status   = status_q;
   assign ctu_cnt      = cnt_q;

endmodule

// File: tb/tb_qdec_cabac_frame_seq.sv
// Self-checking bench for qdec_cabac_frame_seq: directed scenarios plus random frames
// checked against a cycle-level event model of the frame outcome.
module tb_qdec_cabac_frame_seq;
   localparam int TMO = 16;

   logic        clk = 1'b0, rst = 1'b1, frm_vld = 1'b0, frm_rdy;
   logic [31:0] vps0 = '0, sps0 = '0, sps1 = '0, pps0 = '0, slh0 = '0;
   logic [15:0] num_ctu = '0, ctu_cnt;
   logic        req_vld, req_rdy = 1'b1, resp_vld = 1'b0;
   logic [31:0] req_addr, req_wdata;
   logic        ctu = 1'b0, dn = 1'b0, err = 1'b0;
   logic        busy, frm_done;
   logic [1:0]  frm_status;

   int          n_chk = 0, n_fail = 0, done_seen = 0;
   logic [63:0] wq[$];
   logic        hs_pend = 1'b0;
   logic [31:0] exp_w[6];
   logic [31:0] exp_addr[6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h000};

   qdec_cabac_frame_seq #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .frm_vld(frm_vld), .frm_rdy(frm_rdy),
      .frm_vps0(vps0), .frm_sps0(sps0), .frm_sps1(sps1), .frm_pps0(pps0), .frm_slh0(slh0),
      .frm_num_ctu(num_ctu), .reg_req_vld(req_vld), .reg_req_rdy(req_rdy),
      .reg_req_addr(req_addr), .reg_req_wdata(req_wdata), .reg_resp_vld(resp_vld),
      .ctu_done_intr(ctu), .done_intr(dn), .error_intr(err), .busy(busy),
      .frm_done(frm_done), .frm_status(frm_status), .ctu_cnt(ctu_cnt)
   );

   always #5 clk = ~clk;

   // Register slave: log each handshake and answer one cycle after it.
   always @(negedge clk) begin
      resp_vld = hs_pend;
      hs_pend  = req_vld && req_rdy && !rst;
      if (hs_pend) wq.push_back({req_addr, req_wdata});
      if (frm_done === 1'b1) done_seen++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse(input logic c, input logic d, input logic e);
      ctu = c; dn = d; err = e;
      tick();
      ctu = 1'b0; dn = 1'b0; err = 1'b0;
   endtask

   task automatic send(input logic [15:0] n);
      for (int i = 0; i < 5; i++) exp_w[i] = $urandom;
      exp_w[5] = 32'h1;
      {vps0, sps0, sps1, pps0, slh0} = {exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4]};
      num_ctu = n; frm_vld = 1'b1;
      tick();
      frm_vld = 1'b0;
      wq.delete(); done_seen = 0;
   endtask

   // Returns with the DUT in its first RUN cycle.
   task automatic wait_run(input bit rand_rdy, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (wq.size() == 6) begin ok = 1'b1; break; end
         if (rand_rdy) req_rdy = 1'($urandom_range(0, 1));
         tick();
      end
      req_rdy = 1'b1;
      tick();
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int k = 0; k < 100; k++) begin
         if (frm_done === 1'b1) begin cyc = k; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick();
      n_chk++; if (frm_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", frm_rdy); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_chk++; if (req_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", req_vld); end
      n_chk++; if ({frm_done, frm_status, ctu_cnt} !== 19'd0) begin
         n_fail++; $display("FAIL reset_outs got %b/%0d/%0d want 0/0/0", frm_done, frm_status, ctu_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      bit ok; int cyc;
      send(16'd4);
      wait_run(1'b0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL nom_writes got %0d want 6", wq.size()); end
      repeat (4) pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      wait_done(cyc);
      n_chk++; if (cyc < 0) begin n_fail++; $display("FAIL nom_done got none want pulse"); end
      for (int i = 0; i < 6; i++) begin
         n_chk++;
         if (i >= wq.size() || wq[i] !== {exp_addr[i], exp_w[i]}) begin
            n_fail++; $display("FAIL nom_write%0d got %h want %h", i,
                               (i < wq.size()) ? wq[i] : 64'hx, {exp_addr[i], exp_w[i]});
         end
      end
      n_chk++; if (frm_status !== 2'd0) begin n_fail++; $display("FAIL nom_status got %0d want 0", frm_status); end
      n_chk++; if (ctu_cnt !== 16'd4) begin n_fail++; $display("FAIL nom_cnt got %0d want 4", ctu_cnt); end
      tick();
      n_chk++; if (frm_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL nom_idle got done=%b busy=%b want 0/0", frm_done, busy);
      end
      pulse(1'b1, 1'b1, 1'b1); tick();
      n_chk++; if (done_seen != 1) begin n_fail++; $display("FAIL nom_done_count got %0d want 1", done_seen); end
      n_chk++; if (ctu_cnt !== 16'd4 || frm_status !== 2'd0) begin
         n_fail++; $display("FAIL nom_hold got %0d/%0d want 4/0", ctu_cnt, frm_status);
      end
   endtask

   task automatic test_backpressure();
      bit stalled = 1'b0; int cyc;
      send(16'd1);
      for (int k = 0; k < 200 && wq.size() < 6; k++) begin
         if (req_vld && wq.size() == 2 && !stalled) begin
            stalled = 1'b1; req_rdy = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               n_chk++;
               if (req_vld !== 1'b1 || req_addr !== exp_addr[2] || req_wdata !== exp_w[2]) begin
                  n_fail++; $display("FAIL bp_stall%0d got %b %h %h want 1 %h %h", s, req_vld,
                                     req_addr, req_wdata, exp_addr[2], exp_w[2]);
               end
            end
            req_rdy = 1'b1;
         end
         tick();
      end
      tick();
      pulse(1'b1, 1'b1, 1'b0);
      wait_done(cyc);
      n_chk++; if (wq.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", wq.size()); end
      for (int i = 0; i < 6 && i < wq.size(); i++) begin
         n_chk++;
         if (wq[i] !== {exp_addr[i], exp_w[i]}) begin
            n_fail++; $display("FAIL bp_write%0d got %h want %h", i, wq[i], {exp_addr[i], exp_w[i]});
         end
      end
      n_chk++; if (frm_status !== 2'd0) begin n_fail++; $display("FAIL bp_status got %0d want 0", frm_status); end
      tick();
   endtask

   task automatic test_simultaneous();
      bit ok; int cyc;
      send(16'd1); wait_run(1'b0, ok);
      pulse(1'b1, 1'b1, 1'b1);
      wait_done(cyc);
      n_chk++; if (cyc != 0) begin n_fail++; $display("FAIL sim_latency got %0d want 0", cyc); end
      n_chk++; if (frm_status !== 2'd1) begin n_fail++; $display("FAIL sim_status got %0d want 1", frm_status); end
      n_chk++; if (ctu_cnt !== 16'd1) begin n_fail++; $display("FAIL sim_cnt got %0d want 1", ctu_cnt); end
      tick();
   endtask

   task automatic test_mismatch();
      bit ok; int cyc;
      send(16'd5); wait_run(1'b0, ok);
      repeat (3) pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      wait_done(cyc);
      n_chk++; if (frm_status !== 2'd3) begin n_fail++; $display("FAIL mm_status got %0d want 3", frm_status); end
      n_chk++; if (ctu_cnt !== 16'd3) begin n_fail++; $display("FAIL mm_cnt got %0d want 3", ctu_cnt); end
      tick();
   endtask

   task automatic test_timeout();
      bit ok; int cyc;
      send(16'd2); wait_run(1'b0, ok);
      wait_done(cyc);
      n_chk++; if (cyc != TMO) begin n_fail++; $display("FAIL tmo_latency got %0d want %0d", cyc, TMO); end
      n_chk++; if (frm_status !== 2'd2) begin n_fail++; $display("FAIL tmo_status got %0d want 2", frm_status); end
      tick();
   endtask

   task automatic test_reset_in_run();
      bit ok;
      send(16'd4); wait_run(1'b0, ok);
      repeat (2) pulse(1'b1, 1'b0, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      n_chk++; if (frm_rdy !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rir_idle got rdy=%b busy=%b want 1/0", frm_rdy, busy);
      end
      n_chk++; if (ctu_cnt !== 16'd0 || frm_status !== 2'd0) begin
         n_fail++; $display("FAIL rir_clear got %0d/%0d want 0/0", ctu_cnt, frm_status);
      end
      repeat (TMO + 4) tick();
      n_chk++; if (done_seen != 0) begin n_fail++; $display("FAIL rir_nodone got %0d want 0", done_seen); end
   endtask

   task automatic test_reset_mid_write();
      send(16'd1);
      req_rdy = 1'b0; tick(); tick();
      n_chk++; if (req_vld !== 1'b1) begin n_fail++; $display("FAIL rmw_vld_pre got %b want 1", req_vld); end
      rst = 1'b1; tick(); rst = 1'b0; req_rdy = 1'b1;
      n_chk++; if (req_vld !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rmw_drop got vld=%b busy=%b want 0/0", req_vld, busy);
      end
      tick();
   endtask

   task automatic test_random();
      for (int f = 0; f < 20; f++) begin
         bit ok; int len, exp_cyc, exp_cnt, cnt, quiet, got;
         logic [1:0] exp_st;
         logic [15:0] n;
         logic ev_c[40], ev_d[40], ev_e[40];
         n = 16'($urandom_range(0, 4));
         len = $urandom_range(1, 30);
         for (int i = 0; i < 40; i++) begin
            ev_c[i] = (i < len) && ($urandom_range(0, 2) == 0);
            ev_d[i] = (i < len) && ($urandom_range(0, 11) == 0);
            ev_e[i] = (i < len) && ($urandom_range(0, 24) == 0);
         end
         // Outcome: first cycle with error, done, or TMO consecutive CTU-free cycles.
         cnt = 0; quiet = 0; exp_cyc = -1; exp_st = 2'd0; exp_cnt = 0;
         for (int i = 0; i < 40 + TMO && exp_cyc < 0; i++) begin
            logic c, d, e;
            c = (i < 40) ? ev_c[i] : 1'b0;
            d = (i < 40) ? ev_d[i] : 1'b0;
            e = (i < 40) ? ev_e[i] : 1'b0;
            if (c) cnt++;
            quiet = c ? 0 : quiet + 1;
            if (e) exp_st = 2'd1;
            else if (d) exp_st = (cnt == int'(n)) ? 2'd0 : 2'd3;
            else if (quiet == TMO) exp_st = 2'd2;
            if (e || d || quiet == TMO) begin exp_cyc = i + 1; exp_cnt = cnt; end
         end
         send(n); wait_run(1'b1, ok);
         got = -1;
         for (int t = 0; t < 40 + TMO + 4; t++) begin
            if (frm_done === 1'b1 && got < 0) got = t;
            if (t < 40) begin ctu = ev_c[t]; dn = ev_d[t]; err = ev_e[t]; end
            else begin ctu = 1'b0; dn = 1'b0; err = 1'b0; end
            tick();
         end
         ctu = 1'b0; dn = 1'b0; err = 1'b0;
         n_chk++; if (!ok || wq.size() != 6 || wq[5] !== {exp_addr[5], 32'h1} || wq[2] !== {exp_addr[2], exp_w[2]}) begin
            n_fail++; $display("FAIL rnd%0d_writes got %0d writes want 6 in order", f, wq.size());
         end
         n_chk++; if (got != exp_cyc) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", f, got, exp_cyc); end
         n_chk++; if (frm_status !== exp_st) begin n_fail++; $display("FAIL rnd%0d_status got %0d want %0d", f, frm_status, exp_st); end
         n_chk++; if (ctu_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rnd%0d_cnt got %0d want %0d", f, ctu_cnt, exp_cnt); end
         n_chk++; if (done_seen != 1) begin n_fail++; $display("FAIL rnd%0d_done_count got %0d want 1", f, done_seen); end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_simultaneous();
      test_mismatch();
      test_timeout();
      test_reset_in_run();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
